// File: rtl/operand_negate_seq_8b_if.sv
// Handshake bundle for operand_negate_seq_8b: operand request side and result side.
// The flag signals exist only when NEG_FLAGS_EN is defined.
interface operand_negate_seq_8b_if;
  logic       input_valid;
  logic       output_ready;
  logic [7:0] input_a;
  logic [1:0] input_mode;
  logic       output_valid;
  logic       input_ready;
  logic [7:0] output_z;
  logic       output_carry;
`ifdef NEG_FLAGS_EN
  logic       output_overflow;
  logic       output_zero;

  modport master (
    output input_valid, input_a, input_mode, input_ready,
    input  output_ready, output_valid, output_z, output_carry, output_overflow, output_zero
  );
  modport slave (
    input  input_valid, input_a, input_mode, input_ready,
    output output_ready, output_valid, output_z, output_carry, output_overflow, output_zero
  );
`else
  modport master (
    output input_valid, input_a, input_mode, input_ready,
    input  output_ready, output_valid, output_z, output_carry
  );
  modport slave (
    input  input_valid, input_a, input_mode, input_ready,
    output output_ready, output_valid, output_z, output_carry
  );
`endif
endinterface

// File: rtl/operand_negate_seq_8b.sv
// Sequenced pass / invert / negate / abs stage ahead of the ALU B port, one operation in flight.
// Optional macro NEG_FLAGS_EN adds registered output_overflow and output_zero flags.

module bitwise_inverter_8b (
  input  logic [7:0] input_a,
  input  logic       input_enable,
  output logic [7:0] output_z
);
  // Conditional one's complement.
  always_comb begin
    if (input_enable) begin
      output_z = ~input_a;
    end else begin
      output_z = input_a;
    end
  end
endmodule

module operand_negate_seq_8b #(
  parameter int WIDTH = 8
) (
  input  logic                   input_clock,
  input  logic                   input_reset_n,
  operand_negate_seq_8b_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_INVERT    = 2'd1,
    ST_INCREMENT = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] inv_q, inv_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
`ifdef NEG_FLAGS_EN
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
`endif

  logic             inv_en_s;
  logic             cin_s;
  logic             ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] inv_out_s;
  logic [WIDTH:0]   sum9_s;

  // Abs only inverts (and later adds one) when the operand is negative.
  always_comb begin
    inv_en_s = (mode_q == 2'b01) | (mode_q == 2'b10) | ((mode_q == 2'b11) & a_q[WIDTH-1]);
    cin_s    = inv_en_s & (mode_q != 2'b01);
    sum9_s   = {1'b0, inv_q} + {{WIDTH{1'b0}}, cin_s};
    ready_s  = (state_q == ST_IDLE) & input_reset_n;
    accept_s = bus.input_valid & ready_s;
  end

  bitwise_inverter_8b u_inverter (
    .input_a      (a_q),
    .input_enable (inv_en_s),
    .output_z     (inv_out_s)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    mode_d  = mode_q;
    inv_d   = inv_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef NEG_FLAGS_EN
    ovf_d   = ovf_q;
    zero_d  = zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          a_d     = bus.input_a;
          mode_d  = bus.input_mode;
          state_d = ST_INVERT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INVERT: begin
        inv_d   = inv_out_s;
        state_d = ST_INCREMENT;
      end
      ST_INCREMENT: begin
        carry_d = sum9_s[WIDTH];
        sum_d   = sum9_s[WIDTH-1:0];
`ifdef NEG_FLAGS_EN
        ovf_d   = ((mode_q == 2'b10) | (mode_q == 2'b11)) & (a_q == 8'h80);
        zero_d  = (sum9_s[WIDTH-1:0] == 8'h00);
`endif
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (bus.input_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge input_clock) begin
    if (!input_reset_n) begin
      state_q <= ST_IDLE;
      a_q     <= 8'h00;
      mode_q  <= 2'b00;
      inv_q   <= 8'h00;
      sum_q   <= 8'h00;
      carry_q <= 1'b0;
`ifdef NEG_FLAGS_EN
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      mode_q  <= mode_d;
      inv_q   <= inv_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef NEG_FLAGS_EN
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign bus.output_ready    = ready_s;
  assign bus.output_valid    = (state_q == ST_DONE);
  assign bus.output_z        = sum_q;
  assign bus.output_carry    = carry_q;
`ifdef NEG_FLAGS_EN
  assign bus.output_overflow = ovf_q;
  assign bus.output_zero     = zero_q;
`endif

endmodule

// File: tb/tb_operand_negate_seq_8b.sv
// Scoreboard bench for operand_negate_seq_8b: driver pushes reference results, monitor pops on handshake.
module tb_operand_negate_seq_8b;

  typedef struct packed {
    logic [7:0] z;
    logic       carry;
    logic       ovf;
    logic       zero;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  exp_t mon_e;

  operand_negate_seq_8b_if bus ();

  operand_negate_seq_8b dut (
    .input_clock   (clk),
    .input_reset_n (rst_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic modulo 256.
  function automatic exp_t model(input logic [7:0] a, input logic [1:0] mode);
    exp_t e;
    int   v;
    int   r;
    v = int'(a);
    case (mode)
      2'd0:    r = v;
      2'd1:    r = 255 - v;
      2'd2:    r = (256 - v) % 256;
      default: r = (v >= 128) ? (256 - v) : v;
    endcase
    e.z     = r[7:0];
    e.carry = (mode == 2'd2) && (v == 0);
    e.ovf   = (mode >= 2'd2) && (v == 128);
    e.zero  = (r == 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: exclusivity every cycle, result comparison on each output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_valid_excl", 32'(bus.output_ready & bus.output_valid), 32'd0);
      if (bus.output_valid && bus.input_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got z=%0h expected no result", bus.output_z);
        end else begin
          mon_e = exp_q.pop_front();
          chk("result_z", 32'(bus.output_z), 32'(mon_e.z));
          chk("result_carry", 32'(bus.output_carry), 32'(mon_e.carry));
`ifdef NEG_FLAGS_EN
          chk("result_overflow", 32'(bus.output_overflow), 32'(mon_e.ovf));
          chk("result_zero", 32'(bus.output_zero), 32'(mon_e.zero));
`endif
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.output_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", 32'(bus.output_ready), 32'd1);
  endtask

  task automatic txn(input logic [7:0] a, input logic [1:0] mode, input int stall, input bit busy);
    int         lat;
    logic [7:0] z0;
    wait_ready();
    bus.input_valid = 1'b1;
    bus.input_a     = a;
    bus.input_mode  = mode;
    bus.input_ready = 1'b0;
    @(posedge clk);
    exp_q.push_back(model(a, mode));
    #1;
    bus.input_valid = busy;
    bus.input_a     = busy ? 8'h33 : 8'($urandom);
    bus.input_mode  = 2'($urandom);
    // lat counts cycles with the accepting cycle as cycle 0.
    lat = 1;
    while (!bus.output_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      bus.input_valid = 1'b0;
      bus.input_a     = 8'($urandom);
    end
    chk("latency", 32'(lat), 32'd3);
    z0 = bus.output_z;
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", 32'(bus.output_valid), 32'd1);
      chk("stall_z_stable", 32'(bus.output_z), 32'(z0));
      chk("stall_ready_low", 32'(bus.output_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.input_ready = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_consume", 32'({bus.output_valid, bus.output_ready}), 32'b01);
  endtask

  task automatic reset_mid();
    wait_ready();
    bus.input_valid = 1'b1;
    bus.input_a     = 8'h05;
    bus.input_mode  = 2'b10;
    bus.input_ready = 1'b0;
    @(posedge clk); #1;
    bus.input_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", 32'(bus.output_valid), 32'd0);
    chk("midrst_ready", 32'(bus.output_ready), 32'd0);
    chk("midrst_z", 32'(bus.output_z), 32'd0);
    rst_n = 1'b1;
    bus.input_ready = 1'b1;
    @(posedge clk); #1;
    chk("midrst_idle", 32'({bus.output_valid, bus.output_ready}), 32'b01);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_result", 32'(bus.output_valid), 32'd0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.input_valid = 1'b0;
    bus.input_a     = 8'h00;
    bus.input_mode  = 2'b00;
    bus.input_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus.output_valid), 32'd0);
    chk("reset_ready", 32'(bus.output_ready), 32'd0);
    chk("reset_z", 32'(bus.output_z), 32'd0);
    chk("reset_carry", 32'(bus.output_carry), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_ready", 32'(bus.output_ready), 32'd1);

    txn(8'hA5, 2'b00, 0, 1'b0);
    txn(8'h00, 2'b01, 0, 1'b0);
    txn(8'hFF, 2'b01, 0, 1'b0);
    txn(8'h01, 2'b10, 0, 1'b0);
    txn(8'h00, 2'b10, 0, 1'b0);
    txn(8'h80, 2'b10, 0, 1'b0);
    txn(8'hF6, 2'b11, 0, 1'b0);
    txn(8'h0A, 2'b11, 0, 1'b0);
    txn(8'h80, 2'b11, 0, 1'b0);
    txn(8'h5A, 2'b10, 5, 1'b0);
    txn(8'h9C, 2'b11, 1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    reset_mid();

    for (int k = 0; k < 40; k++) begin
      txn(8'($urandom), 2'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
